gcd_requester: RTL
==================

// Module: gcd_requester
// PURPOSE
//  Initiator side of the start/done GCD engine handshake.
//  - Accepts operand pairs from an upstream valid/ready stream.
//  - Drives start/operands to one GCD engine using a four-phase handshake.
//  - Captures each result and presents it on a downstream valid/ready stream.
//  - Sits between a command source (CPU regs or DMA) and the GCD engine.
// PARAMETERS
//  W        8     operand/result width
//  CNT_W    16    width of completed-request counter
//  TO_CYC   1024  watchdog limit in cycles (used only with GCD_TIMEOUT_EN)
// PORTS
//  clock       in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  op_valid    in   1      operand pair valid
//  op_ready    out  1      block can accept an operand pair
//  op_a        in   W      operand A
//  op_b        in   W      operand B
//  res_valid   out  1      result valid
//  res_ready   in   1      downstream accepts result
//  res_gcd     out  W      GCD result
//  res_err     out  1      result aborted by watchdog; constant 0 without macro
//  gcd_start   out  1      request to engine, level
//  gcd_a       out  W      operand A to engine, stable while gcd_start=1
//  gcd_b       out  W      operand B to engine, stable while gcd_start=1
//  gcd_done    in   1      engine completion, level
//  gcd_result  in   W      engine result, valid while gcd_done=1
//  busy        out  1      state != IDLE
//  req_count   out  CNT_W  results delivered downstream (wraps)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: gcd_start, gcd_a/b, res_valid, res_gcd,
//   res_err, req_count. op_ready=0 while reset is asserted.
//   Reset mid-operation drops gcd_start immediately; no result is produced.
//  FSM states:
//   IDLE -> REQ      on op_valid && op_ready; latch op_a/op_b into gcd_a/gcd_b.
//   REQ  -> REL      on gcd_done=1; gcd_start=1 throughout REQ.
//                    Capture gcd_result into res_gcd; set res_valid next cycle.
//   REL  -> IDLE     on gcd_done=0; gcd_start=0 throughout REL.
//  Handshakes:
//   op_ready = (state==IDLE) && !res_valid. One request in flight; no queueing.
//   Downstream: res_valid stays high and res_gcd stays stable until
//    res_valid && res_ready. On that handshake, clear res_valid and
//    increment req_count in the same cycle.
//   Results may drain while the FSM is in REL; this does not stall the engine.
//  Latency: op accepted at cycle 0 -> gcd_start=1 at cycle 1.
//   gcd_done sampled high at cycle N -> res_valid=1 and gcd_start=0 at N+1.
//  Boundaries:
//   - Zero operands are forwarded unchanged. The engine defines
//     gcd(0,b)=b and gcd(0,0)=0.
//   - gcd_done already high in IDLE (stale): ignored; only REQ samples it.
//   - op_valid held high while op_ready=0: not accepted; no side effects.
//   - req_count wraps from 2^CNT_W-1 to 0.
// CONFIGURATION
//  GCD_TIMEOUT_EN defined:
//   - Watchdog counts cycles in REQ and in REL.
//   - REQ reaching TO_CYC without gcd_done: go to REL, res_gcd=0, res_err=1,
//     res_valid=1.
//   - REL reaching TO_CYC with gcd_done still high: force IDLE.
//     No extra result is produced.
//   - Counter clears on every state change.
//  GCD_TIMEOUT_EN undefined: no counter logic; res_err tied 0;
//   FSM waits indefinitely.
// STRUCTURE
//  gcd_pkg: state encodings (IDLE/REQ/REL, 2 bits) and default W.
//  Sub-module gcd_watchdog (counter + terminal flag), instantiated only
//   under GCD_TIMEOUT_EN.
//  FSM, operand and result registers, and counter stay in gcd_requester.
// TESTING
//  1. Reset, then op (48,18) with a behavioural four-phase engine
//     -> res_gcd=6, res_err=0, req_count=1.
//  2. op (0,7) then (0,0) back-to-back, res_ready=1
//     -> results 7 then 0, in order, each exactly once.
//  3. res_ready=0 for 20 cycles after result (255,15)
//     -> res_valid and res_gcd=15 held stable; op_ready=0 throughout;
//        next op accepted only after the drain.
//  4. Assert reset while in REQ -> gcd_start=0 in the same cycle;
//     res_valid=0; req_count=0.
//  5. Engine holds gcd_done=1 while IDLE, then op (12,8) is issued
//     -> stale done ignored in IDLE; result 4 is captured after the
//        engine's real cycle.
//  6. GCD_TIMEOUT_EN, TO_CYC=16, engine never asserts done
//     -> res_valid at cycle 17 with res_err=1 and res_gcd=0; FSM returns
//        to IDLE once gcd_done=0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester slice.
//   gcd_state_e : requester FSM encoding (IDLE / REQ / REL), 2 bits
//   GCD_W_DEF   : default operand/result width
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } gcd_state_e;

  localparam int GCD_W_DEF = 8;

endpackage

// File: rtl/gcd_watchdog.sv
// Cycle watchdog for the GCD requester. It only exists when GCD_TIMEOUT_EN
// is defined, because the requester has no counter logic otherwise.
//   clock     : clock, rising edge
//   reset     : asynchronous, active-high
//   en_i      : count this cycle (FSM in a waiting state)
//   clr_i     : restart from zero (FSM changes state this cycle)
//   expired_o : TO_CYC cycles have been spent in the current state
`ifdef GCD_TIMEOUT_EN
module gcd_watchdog #(
  parameter int TO_CYC = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds 0 in the first cycle of a state, so a value of
  // TO_CYC-1 means this is the TO_CYC-th cycle in that state.
  assign expired_o = (cnt_q == CW'(TO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/gcd_requester.sv
// Initiator side of the four-phase start/done GCD engine handshake.
// Takes operand pairs from an upstream valid/ready stream, runs one
// request at a time on the engine and presents each result downstream.
//
// Optional feature macro: GCD_TIMEOUT_EN (watchdog on REQ and REL; adds
// res_err reporting). Without it the FSM waits indefinitely, res_err = 0.
//
// Ports:
//   clock, reset            clock (rising) / asynchronous active-high reset
//   op_valid/op_ready       upstream handshake, op_a/op_b operands
//   res_valid/res_ready     downstream handshake, res_gcd result,
//                           res_err watchdog abort flag
//   gcd_start, gcd_a/gcd_b  request level and operands to the engine
//   gcd_done, gcd_result    completion level and result from the engine
//   busy                    FSM not in IDLE
//   req_count               results delivered downstream (wraps)
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int W      = GCD_W_DEF,
  parameter int CNT_W  = 16,
  parameter int TO_CYC = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_gcd,
  output logic             res_err,
  output logic             gcd_start,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  input  logic             gcd_done,
  input  logic [W-1:0]     gcd_result,
  output logic             busy,
  output logic [CNT_W-1:0] req_count
);

  gcd_state_e       state_q, state_d;
  logic [W-1:0]     gcd_a_q, gcd_a_d;
  logic [W-1:0]     gcd_b_q, gcd_b_d;
  logic [W-1:0]     res_gcd_q, res_gcd_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             res_fire;

`ifdef GCD_TIMEOUT_EN
  logic res_err_q, res_err_d;
  logic wd_expired;
  logic wd_en;
  logic wd_clr;

  assign wd_en  = (state_q == ST_REQ) || (state_q == ST_REL);
  assign wd_clr = (state_d != state_q);

  gcd_watchdog #(
    .TO_CYC (TO_CYC)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .en_i      (wd_en),
    .clr_i     (wd_clr),
    .expired_o (wd_expired)
  );

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  // op_ready is forced low during reset; state alone would show IDLE.
  assign op_ready  = (state_q == ST_IDLE) && !res_valid_q && !reset;
  assign accept    = op_valid && op_ready;
  assign res_fire  = res_valid_q && res_ready;

  // Decoded from state so an asynchronous reset drops the request at once.
  assign gcd_start = (state_q == ST_REQ);
  assign busy      = (state_q != ST_IDLE);
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign res_valid = res_valid_q;
  assign res_gcd   = res_gcd_q;
  assign req_count = count_q;

  always_comb begin
    state_d     = state_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    res_gcd_d   = res_gcd_q;
    res_valid_d = res_valid_q;
    count_d     = count_q;
`ifdef GCD_TIMEOUT_EN
    res_err_d   = res_err_q;
`endif

    // A result can only be captured in REQ, which is never entered while
    // res_valid is high, so draining and capturing never collide.
    if (res_fire) begin
      res_valid_d = 1'b0;
      count_d     = count_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // gcd_done is deliberately not looked at here: a stale done from
        // the engine must not produce a result.
        if (accept) begin
          state_d = ST_REQ;
          gcd_a_d = op_a;
          gcd_b_d = op_b;
        end
      end
      ST_REQ: begin
        if (gcd_done) begin
          state_d     = ST_REL;
          res_gcd_d   = gcd_result;
          res_valid_d = 1'b1;
`ifdef GCD_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (wd_expired) begin
          state_d     = ST_REL;
          res_gcd_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
`endif
        end
      end
      ST_REL: begin
        if (!gcd_done) begin
          state_d = ST_IDLE;
`ifdef GCD_TIMEOUT_EN
        end else if (wd_expired) begin
          // Engine never released done; abandon it without a second result.
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      res_gcd_q   <= '0;
      res_valid_q <= 1'b0;
      count_q     <= '0;
`ifdef GCD_TIMEOUT_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      res_gcd_q   <= res_gcd_d;
      res_valid_q <= res_valid_d;
      count_q     <= count_d;
`ifdef GCD_TIMEOUT_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

endmodule
